// File: rtl/sixteen_two.sv
// Registered 16x2 unsigned leaf multiplier producing an 18-bit product.
// When APPROX_BITS > 0, the low segment uses a lower-part-OR adder with no carry into the upper segment.
module sixteen_two #(
    parameter int unsigned APPROX_BITS = 0
) (
    input  logic [15:0] a,
    input  logic [1:0]  b,
    input  logic        clk,
    input  logic        rst,
    output logic [17:0] m
);

    logic [17:0] pp0;
    logic [17:0] pp1;
    logic [17:0] p;
    logic        carry;

    assign pp0 = {2'b00, a & {16{b[0]}}};
    assign pp1 = {1'b0, a & {16{b[1]}}, 1'b0};

    // Ripple-carry adder. Below APPROX_BITS each sum bit is the OR of the inputs,
    // and the carry is held at zero so the upper segment starts with no carry-in.
    always_comb begin
        p     = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < 18; i++) begin
            if (i < APPROX_BITS) begin
                p[i]  = pp0[i] | pp1[i];
                carry = 1'b0;
            end else begin
                p[i]  = pp0[i] ^ pp1[i] ^ carry;
                carry = (pp0[i] & pp1[i]) | (carry & (pp0[i] ^ pp1[i]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m <= '0;
        end else begin
            m <= p;
        end
    end

endmodule

// File: tb/tb_sixteen_two.sv
// Directed and random checks of sixteen_two in exact mode (K=0) and approximate mode (K=4).
module tb_sixteen_two;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [1:0]  b;
    logic [17:0] m0;
    logic [17:0] m4;

    int checks;
    int failures;

    sixteen_two #(.APPROX_BITS(0)) dut_exact (
        .a   (a),
        .b   (b),
        .clk (clk),
        .rst (rst),
        .m   (m0)
    );

    sixteen_two #(.APPROX_BITS(4)) dut_approx (
        .a   (a),
        .b   (b),
        .clk (clk),
        .rst (rst),
        .m   (m4)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a   = 16'hF003;
        b   = 2'd3;
        step();
        checks++;
        if (m0 !== 18'h0) begin
            failures++;
            $display("FAIL reset_exact: m=%h expected %h", m0, 18'h0);
        end
        checks++;
        if (m4 !== 18'h0) begin
            failures++;
            $display("FAIL reset_approx: m=%h expected %h", m4, 18'h0);
        end
    endtask

    task automatic test_exact_hold();
        rst = 1'b0;
        a   = 16'hF003;
        b   = 2'd3;
        step();
        checks++;
        if (m0 !== 18'h2D009) begin
            failures++;
            $display("FAIL first_product: m=%h expected %h", m0, 18'h2D009);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (m0 !== 18'h2D009) begin
                failures++;
                $display("FAIL hold_%0d: m=%h expected %h", i, m0, 18'h2D009);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'hFFFF, 16'h1234, 16'hABCD, 16'h8000};
        logic [1:0]  vb [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        logic [17:0] ve [4] = '{18'h2FFFD, 18'h02468, 18'h0ABCD, 18'h00000};
        for (int i = 0; i < 4; i++) begin
            a = va[i];
            b = vb[i];
            step();
            checks++;
            if (m0 !== ve[i]) begin
                failures++;
                $display("FAIL b2b_%0d: m=%h expected %h", i, m0, ve[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        a   = 16'hF003;
        b   = 2'd3;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (m0 !== 18'h0) begin
            failures++;
            $display("FAIL midreset: m=%h expected %h", m0, 18'h0);
        end
        rst = 1'b0;
        step();
        checks++;
        if (m0 !== 18'h2D009) begin
            failures++;
            $display("FAIL after_reset_exact: m=%h expected %h", m0, 18'h2D009);
        end
        checks++;
        if (m4 !== 18'h2D007) begin
            failures++;
            $display("FAIL after_reset_approx: m=%h expected %h", m4, 18'h2D007);
        end
    endtask

    task automatic test_approx();
        a = 16'h0003;
        b = 2'd3;
        step();
        checks++;
        if (m4 !== 18'h00007) begin
            failures++;
            $display("FAIL approx_3x3: m=%h expected %h", m4, 18'h00007);
        end
        checks++;
        if (m0 !== 18'h00009) begin
            failures++;
            $display("FAIL exact_3x3: m=%h expected %h", m0, 18'h00009);
        end
        a = 16'h0010;
        step();
        checks++;
        if (m4 !== 18'h00030) begin
            failures++;
            $display("FAIL approx_0x10x3: m=%h expected %h", m4, 18'h00030);
        end
    endtask

    task automatic test_approx_boundary();
        logic [17:0] ve [3] = '{18'h00000, 18'h0F003, 18'h1E006};
        a = 16'hF003;
        for (int i = 0; i < 3; i++) begin
            b = 2'(i);
            step();
            checks++;
            if (m4 !== ve[i]) begin
                failures++;
                $display("FAIL approx_b%0d: m=%h expected %h", i, m4, ve[i]);
            end
        end
        a = 16'h0000;
        b = 2'd3;
        step();
        checks++;
        if (m4 !== 18'h0 || m0 !== 18'h0) begin
            failures++;
            $display("FAIL a_zero: m0=%h m4=%h expected 0", m0, m4);
        end
    endtask

    task automatic test_regression();
        logic [17:0] exact;
        logic [17:0] q0;
        logic [17:0] q1;
        logic [17:0] approx;
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 2'($urandom_range(0, 3));
            exact  = 18'(a) * 18'(b);
            q0     = b[0] ? {2'b00, a} : 18'h0;
            q1     = b[1] ? {1'b0, a, 1'b0} : 18'h0;
            approx = ((q0 | q1) & 18'h0000F) | ((((q0 >> 4) + (q1 >> 4)) << 4) & 18'h3FFF0);
            step();
            checks++;
            if (m0 !== exact) begin
                failures++;
                $display("FAIL rand_exact a=%h b=%0d: m=%h expected %h", a, b, m0, exact);
            end
            checks++;
            if (m4 !== approx) begin
                failures++;
                $display("FAIL rand_approx a=%h b=%0d: m=%h expected %h", a, b, m4, approx);
            end
            checks++;
            if (m4 > exact || (exact - m4) > 18'd15) begin
                failures++;
                $display("FAIL rand_error_bound a=%h b=%0d: m=%h exact %h", a, b, m4, exact);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        test_reset();
        test_exact_hold();
        test_back_to_back();
        test_reset_midstream();
        test_approx();
        test_approx_boundary();
        test_regression();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
